// File: rtl/atri_smon_pkg.sv
// Shared constants, FSM state type and helpers for the ATRI sample-monitor statistics block.
// Min/max tracking is compiled in only when ATRI_SMON_MINMAX_EN is defined.
package atri_smon_pkg;

    localparam int NCHAN        = 4;
    localparam int MON_WIDTH    = 8;
    localparam int MAX_LOG2_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } smon_state_e;

    // Requested exponents beyond what the accumulators were sized for are clamped.
    function automatic logic [3:0] clamp_log2(input logic [3:0] n, input logic [3:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/atri_smon_chan_acc.sv
// One monitor channel: running sum plus optional min/max (ATRI_SMON_MINMAX_EN).
module atri_smon_chan_acc
    import atri_smon_pkg::*;
#(
    parameter int ACC_W = MON_WIDTH + MAX_LOG2_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [MON_WIDTH-1:0] sample,
    output logic [ACC_W-1:0]     sum
`ifdef ATRI_SMON_MINMAX_EN
    ,
    output logic [MON_WIDTH-1:0] min_val,
    output logic [MON_WIDTH-1:0] max_val
`endif
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + ACC_W'(sample);
        end
    end

`ifdef ATRI_SMON_MINMAX_EN
    // Min starts at all-ones and max at zero so the first accepted sample replaces both.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            min_val <= '1;
            max_val <= '0;
        end else if (accept) begin
            if (sample < min_val) min_val <= sample;
            if (sample > max_val) max_val <= sample;
        end
    end
`endif

endmodule

// File: rtl/atri_sample_mon_stats.sv
// Averages the four IRS sample-monitor words over 2^N updates and presents them via valid/ack.
// Define ATRI_SMON_MINMAX_EN to also report per-channel min/max.
module atri_sample_mon_stats
    import atri_smon_pkg::*;
#(
    parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       mon_valid_i,
    input  logic [MON_WIDTH-1:0]       irs1_mon_i,
    input  logic [MON_WIDTH-1:0]       irs2_mon_i,
    input  logic [MON_WIDTH-1:0]       irs3_mon_i,
    input  logic [MON_WIDTH-1:0]       irs4_mon_i,
    input  logic [3:0]                 navg_log2_i,
    input  logic                       start_i,
    input  logic                       stat_ack_i,
    output logic                       busy_o,
    output logic                       stat_valid_o,
    output logic [NCHAN*MON_WIDTH-1:0] avg_o,
    output logic [NCHAN*MON_WIDTH-1:0] min_o,
    output logic [NCHAN*MON_WIDTH-1:0] max_o,
    output logic                       overrun_o
);

    localparam int         ACC_W = MON_WIDTH + MAX_LOG2;
    localparam int         CNT_W = MAX_LOG2 + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG2);

    smon_state_e state_q, state_d;

    logic [3:0]                 n_q;
    logic [CNT_W-1:0]           count_q, count_nxt, target;
    logic                       last_q;
    logic                       clear, accept, finish;
    logic [NCHAN*MON_WIDTH-1:0] avg_q, avg_d;
    logic                       overrun_q;
    logic [MON_WIDTH-1:0]       mon [NCHAN];
    logic [ACC_W-1:0]           sum [NCHAN];

    assign mon[0] = irs1_mon_i;
    assign mon[1] = irs2_mon_i;
    assign mon[2] = irs3_mon_i;
    assign mon[3] = irs4_mon_i;

    // Once the final update is in, last_q blocks further accepts while results are registered.
    assign clear     = (state_q == IDLE) && start_i;
    assign accept    = (state_q == ACCUM) && !last_q && mon_valid_i && en_i;
    assign finish    = (state_q == ACCUM) && last_q;
    assign count_nxt = count_q + CNT_W'(1);
    assign target    = CNT_W'(1) << n_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i)    state_d = ACCUM;
            ACCUM:   if (last_q)     state_d = HOLD;
            HOLD:    if (stat_ack_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

`ifdef ATRI_SMON_MINMAX_EN
    logic [MON_WIDTH-1:0]       ch_min [NCHAN];
    logic [MON_WIDTH-1:0]       ch_max [NCHAN];
    logic [NCHAN*MON_WIDTH-1:0] min_d, max_d, min_q, max_q;
`endif

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        atri_smon_chan_acc #(.ACC_W(ACC_W)) u_acc (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear   (clear),
            .accept  (accept),
            .sample  (mon[c]),
            .sum     (sum[c])
`ifdef ATRI_SMON_MINMAX_EN
            ,
            .min_val (ch_min[c]),
            .max_val (ch_max[c])
`endif
        );

        assign avg_d[c*MON_WIDTH +: MON_WIDTH] = MON_WIDTH'(sum[c] >> n_q);
`ifdef ATRI_SMON_MINMAX_EN
        assign min_d[c*MON_WIDTH +: MON_WIDTH] = ch_min[c];
        assign max_d[c*MON_WIDTH +: MON_WIDTH] = ch_max[c];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q       <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            avg_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (clear) begin
                n_q       <= clamp_log2(navg_log2_i, MAX_N);
                count_q   <= '0;
                last_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (accept) begin
                count_q <= count_nxt;
                if (count_nxt == target) last_q <= 1'b1;
            end
            if (finish) begin
                avg_q  <= avg_d;
                last_q <= 1'b0;
            end
            if ((state_q == HOLD) && mon_valid_i && en_i) overrun_q <= 1'b1;
        end
    end

`ifdef ATRI_SMON_MINMAX_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q <= '0;
            max_q <= '0;
        end else if (finish) begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

    assign busy_o       = (state_q == ACCUM);
    assign stat_valid_o = (state_q == HOLD);
    assign avg_o        = avg_q;
    assign overrun_o    = overrun_q;

endmodule

// File: doc/atri_sample_mon_stats.md
# atri_sample_mon_stats

Downstream consumer of the four 8-bit IRS sample-monitor words produced by the ATRI sample monitor. Accumulates each channel's monitor value over 2^N monitor updates, then presents per-channel averages, and optionally min/max, through a valid/ack handshake for register readout. Used for sampling-speed servo diagnostics and Wilkinson/sample-rate health checks.

## Interface
Parameters:
- MAX_LOG2, 10, largest accumulation exponent; accumulator width = 8+MAX_LOG2

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  qualifies mon_valid_i; low = updates ignored
- mon_valid_i  in  1  one-cycle strobe: irsN_mon_i hold a new value
- irs1_mon_i .. irs4_mon_i  in  8 each  monitor words from the sample monitor
- navg_log2_i  in  4  accumulation exponent N, sampled on start_i
- start_i  in  1  one-cycle strobe: begin an acquisition
- stat_ack_i  in  1  consumer has read the results
- busy_o  out  1  acquisition in progress (ACCUM)
- stat_valid_o  out  1  results valid, held until acked
- avg_o  out  32  {irs4,irs3,irs2,irs1} averages, 8 bits each
- min_o  out  32  per-channel minimum, same packing
- max_o  out  32  per-channel maximum, same packing
- overrun_o  out  1  sticky: update arrived while in HOLD

## Operation
- States: IDLE, ACCUM, HOLD. Reset → IDLE.
- IDLE: start_i → latch N = min(navg_log2_i, MAX_LOG2); clear sums and sample count; min regs = 0xFF, max regs = 0x00; clear overrun_o; → ACCUM.
- ACCUM: each cycle with mon_valid_i & en_i: sum += irsN_mon_i per channel; update min/max; count += 1. When the accepted update makes count == 2^N → compute and register results → HOLD.
- Average = sum >> N (truncation, no rounding). Accumulator 8+MAX_LOG2 bits unsigned; cannot overflow.
- HOLD: stat_valid_o = 1; outputs stable. stat_ack_i → IDLE (results remain on outputs, stat_valid_o drops). mon_valid_i & en_i in HOLD → overrun_o = 1, data discarded.
- start_i outside IDLE ignored. en_i low in ACCUM pauses counting; no timeout.
- N = 0: one update completes the acquisition; average = that sample.
- stat_ack_i while not in HOLD ignored. start_i and stat_ack_i in the same HOLD cycle: ack taken, start ignored.
- rst_i mid-acquisition: abort, → IDLE, all outputs to reset values next cycle.
- Reset values: busy_o 0, stat_valid_o 0, avg_o/min_o/max_o 0x00000000, overrun_o 0.

## Timing
- start_i at cycle t → busy_o high at t+1; first accepted update at t+1 at the earliest.
- Final accepted update at cycle t → sums updated at t+1, stat_valid_o and results valid at t+2; busy_o low from t+2.
- stat_ack_i at cycle t in HOLD → stat_valid_o low at t+1; new start_i accepted from t+1.
- Back-to-back mon_valid_i every cycle supported; no bubbles required.

## Configuration
- ATRI_SMON_MINMAX_EN defined: min/max tracking compiled in; min_o/max_o loaded with results on entering HOLD.
- Not defined: min/max logic absent; min_o and max_o tied to 0x00000000; averages, handshake and overrun unchanged.

## Structure
- Package atri_smon_pkg: NCHAN = 4, MON_WIDTH = 8, default MAX_LOG2, state enum (IDLE/ACCUM/HOLD).
- Sub-module atri_smon_chan_acc: one channel's sum, min, max with clear/accept inputs; instantiated four times. FSM and counter in the top.

## Test plan
- N=2, channels held at 0x10/0x20/0x30/0x40, four strobes → stat_valid_o at final+2, avg_o = 0x40302010.
- N=1, irs1 samples 0x03, 0x04 → avg byte0 = 0x03 (truncation); with macro min=0x03, max=0x04; without, min_o=max_o=0.
- N=0 → completes after one strobe; navg_log2_i=15 with MAX_LOG2=10 → completes after exactly 1024 strobes.
- en_i low for 3 of 7 strobes, N=2 → completes on the 4th enabled strobe; strobe in HOLD sets overrun_o, cleared by next start_i.
- rst_i asserted mid-ACCUM → next cycle IDLE, all outputs zero; subsequent start_i runs a clean acquisition.
